// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: FSM states, opcodes,
// register indices and reset values.
package mdio_pkg;

  // Frame-decoding states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StOp,
    StPhyad,
    StRegad,
    StTa,
    StRdData,
    StWrData
  } mdio_state_e;

  // Clause-22 opcodes as received MSB first.
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpWrite = 2'b01;

  // Register indices with special behaviour.
  localparam logic [4:0] RegCtrl   = 5'd0;
  localparam logic [4:0] RegStatus = 5'd1;
  localparam logic [4:0] RegPhyId1 = 5'd2;
  localparam logic [4:0] RegPhyId2 = 5'd3;

  // Number of consecutive preamble ones needed before a start bit is accepted.
  localparam logic [5:0] PreambleLen = 6'd32;

  // Control register value after reset.
  localparam logic [15:0] CtrlResetVal = 16'h1140;

  // Status and PHY ID registers are synthesised from inputs/parameters.
  function automatic logic is_read_only(input logic [4:0] addr);
    return (addr == RegStatus) || (addr == RegPhyId1) || (addr == RegPhyId2);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Brings MDC and MDIO into the system clock domain and flags MDC rising edges.
// Both lines go through identical 2-flop chains so sampled data stays aligned
// with the detected edge.
module mdio_sync_edge (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_mdc,
  input  logic i_mdio,
  output logic o_mdc_rise,
  output logic o_mdio
);

  logic [1:0] r_mdc_sync;
  logic [1:0] r_mdio_sync;
  logic       r_mdc_prev;

  // Two-stage synchronizers plus a delayed MDC copy for edge detection.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mdc_sync  <= 2'b00;
      r_mdio_sync <= 2'b00;
      r_mdc_prev  <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[0], i_mdc};
      r_mdio_sync <= {r_mdio_sync[0], i_mdio};
      r_mdc_prev  <= r_mdc_sync[1];
    end
  end

  assign o_mdc_rise = r_mdc_sync[1] & ~r_mdc_prev;
  assign o_mdio     = r_mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: decodes management frames addressed to PHY_ADDR
// and serves a 32 x 16 register file. Reg 0 is the control register, reg 1
// reflects link_up, regs 2/3 return PHY_ID; everything else is plain storage.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [31:0] PHY_ID   = 32'h0141_0CC0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  output logic [15:0] ctrl_reg,
  output logic        soft_reset
);

  logic        w_mdc_rise;
  logic        w_mdio_s;

  mdio_state_e r_state;
  logic [5:0]  r_pre_cnt;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift;
  logic        r_is_read;
  logic [4:0]  r_regad;
  logic [15:0] r_rd_data;
  logic        r_mdio_o;
  logic        r_mdio_oe;
  logic        r_wr_pend;
  logic        r_soft_reset;
  logic [15:0] r_regs [32];

  mdio_state_e w_state_next;
  logic [5:0]  w_pre_cnt_next;
  logic [4:0]  w_bit_cnt_next;
  logic [15:0] w_shift_next;
  logic        w_is_read_next;
  logic [4:0]  w_regad_next;
  logic [15:0] w_rd_data_next;
  logic        w_mdio_o_next;
  logic        w_mdio_oe_next;
  logic        w_wr_pend_next;
  logic [15:0] w_shift_in;
  logic [15:0] w_rd_mux;

  mdio_sync_edge u_sync_edge (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_mdc      (mdc),
    .i_mdio     (mdio_i),
    .o_mdc_rise (w_mdc_rise),
    .o_mdio     (w_mdio_s)
  );

  assign w_shift_in = {r_shift[14:0], w_mdio_s};

  // Read value for the latched register address.
  always_comb begin
    w_rd_mux = r_regs[r_regad];
    case (r_regad)
      RegStatus: w_rd_mux = {13'h0, link_up, 2'b00};
      RegPhyId1: w_rd_mux = PHY_ID[31:16];
      RegPhyId2: w_rd_mux = PHY_ID[15:0];
      default:   ;
    endcase
  end

  // Frame decoder next state; everything advances only on a detected MDC rise.
  always_comb begin
    w_state_next   = r_state;
    w_pre_cnt_next = r_pre_cnt;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_is_read_next = r_is_read;
    w_regad_next   = r_regad;
    w_rd_data_next = r_rd_data;
    w_mdio_o_next  = r_mdio_o;
    w_mdio_oe_next = r_mdio_oe;
    w_wr_pend_next = 1'b0;

    if (w_mdc_rise) begin
      unique case (r_state)
        StIdle: begin
          if (w_mdio_s) begin
            if (r_pre_cnt != PreambleLen) w_pre_cnt_next = r_pre_cnt + 6'd1;
          end else if (r_pre_cnt == PreambleLen) begin
            // This zero is the first start bit.
            w_state_next   = StStart;
            w_pre_cnt_next = 6'd0;
          end else begin
            w_pre_cnt_next = 6'd0;
          end
        end

        StStart: begin
          w_bit_cnt_next = 5'd0;
          w_state_next   = w_mdio_s ? StOp : StIdle;
        end

        StOp: begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'd1) begin
            w_bit_cnt_next = 5'd0;
            if (w_shift_in[1:0] == OpRead) begin
              w_is_read_next = 1'b1;
              w_state_next   = StPhyad;
            end else if (w_shift_in[1:0] == OpWrite) begin
              w_is_read_next = 1'b0;
              w_state_next   = StPhyad;
            end else begin
              w_state_next = StIdle;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 5'd1;
          end
        end

        StPhyad: begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'd4) begin
            w_bit_cnt_next = 5'd0;
            w_state_next   = (w_shift_in[4:0] == PHY_ADDR) ? StRegad : StIdle;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 5'd1;
          end
        end

        StRegad: begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'd4) begin
            w_bit_cnt_next = 5'd0;
            w_regad_next   = w_shift_in[4:0];
            w_state_next   = StTa;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 5'd1;
          end
        end

        StTa: begin
          if (r_is_read) begin
            // First TA edge: take the bus low and snapshot the read data so a
            // later write cannot disturb this transfer.
            w_mdio_oe_next = 1'b1;
            w_mdio_o_next  = 1'b0;
            w_rd_data_next = w_rd_mux;
            w_bit_cnt_next = 5'd0;
            w_state_next   = StRdData;
          end else if (r_bit_cnt == 5'd1) begin
            w_bit_cnt_next = 5'd0;
            w_state_next   = StWrData;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 5'd1;
          end
        end

        StRdData: begin
          if (r_bit_cnt == 5'd16) begin
            w_mdio_oe_next = 1'b0;
            w_mdio_o_next  = 1'b1;
            w_state_next   = StIdle;
          end else begin
            w_mdio_o_next  = r_rd_data[15];
            w_rd_data_next = {r_rd_data[14:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt + 5'd1;
          end
        end

        StWrData: begin
          w_shift_next = w_shift_in;
          if (r_bit_cnt == 5'd15) begin
            w_wr_pend_next = 1'b1;
            w_state_next   = StIdle;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 5'd1;
          end
        end

        default: w_state_next = StIdle;
      endcase
    end
  end

  // Decoder state and MDIO drive; reset releases the bus immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pre_cnt <= 6'd0;
      r_bit_cnt <= 5'd0;
      r_shift   <= 16'h0;
      r_is_read <= 1'b0;
      r_regad   <= 5'd0;
      r_rd_data <= 16'h0;
      r_mdio_o  <= 1'b1;
      r_mdio_oe <= 1'b0;
      r_wr_pend <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pre_cnt <= w_pre_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
      r_is_read <= w_is_read_next;
      r_regad   <= w_regad_next;
      r_rd_data <= w_rd_data_next;
      r_mdio_o  <= w_mdio_o_next;
      r_mdio_oe <= w_mdio_oe_next;
      r_wr_pend <= w_wr_pend_next;
    end
  end

  // Register file commit, one clock after the last write data bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= (i == 0) ? CtrlResetVal : 16'h0;
      end
      r_soft_reset <= 1'b0;
    end else begin
      r_soft_reset <= r_wr_pend && (r_regad == RegCtrl) && r_shift[15];
      if (r_wr_pend && !is_read_only(r_regad)) begin
        // Reset bit is self-clearing, so it is never stored.
        r_regs[r_regad] <= (r_regad == RegCtrl) ? {1'b0, r_shift[14:0]} : r_shift;
      end
    end
  end

  assign mdio_o     = r_mdio_o;
  assign mdio_oe    = r_mdio_oe;
  assign ctrl_reg   = r_regs[RegCtrl];
  assign soft_reset = r_soft_reset;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: acts as the station on an MDIO bus with a
// pull-up and checks register reads, writes and protocol corner cases.
module tb_mdio_responder;

  logic        clock;
  logic        reset;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic        link_up;
  logic [15:0] ctrl_reg;
  logic        soft_reset;

  logic        st_en;
  logic        st_drv;
  int          n_checks;
  int          n_errors;
  int          oe_hi;
  int          sr_hi;

  logic [15:0] rd;
  logic        ta2;
  int          oe_snap;
  int          sr_snap;

  mdio_responder #(
    .PHY_ADDR (5'd1),
    .PHY_ID   (32'h0141_0CC0)
  ) u_dut (
    .clock      (clock),
    .reset      (reset),
    .mdc        (mdc),
    .mdio_i     (mdio_i),
    .mdio_o     (mdio_o),
    .mdio_oe    (mdio_oe),
    .link_up    (link_up),
    .ctrl_reg   (ctrl_reg),
    .soft_reset (soft_reset)
  );

  // Open-drain-like bus with pull-up.
  assign mdio_i = mdio_oe ? mdio_o : (st_en ? st_drv : 1'b1);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mdio_oe) oe_hi++;
    if (soft_reset) sr_hi++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One station-driven bit: data changes while MDC is low.
  task automatic send_bit(input logic b);
    st_en  = 1'b1;
    st_drv = b;
    #80 mdc = 1'b1;
    #80 mdc = 1'b0;
  endtask

  task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad);
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(op[1]);
    send_bit(op[0]);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(regad[i]);
  endtask

  task automatic write_frame(input int pre, input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] data);
    send_header(pre, 2'b01, phy, regad);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 15; i >= 0; i--) send_bit(data[i]);
    st_en = 1'b0;
    #320;
  endtask

  // Station samples the bus on each MDC rise; responder changes ~30 ns later.
  task automatic read_frame(input logic [4:0] phy, input logic [4:0] regad,
                            output logic [15:0] data, output logic ta_bit);
    send_header(32, 2'b10, phy, regad);
    st_en  = 1'b0;
    data   = 16'h0;
    ta_bit = 1'bx;
    for (int k = 1; k <= 18; k++) begin
      #80 mdc = 1'b1;
      if (k == 2) ta_bit = mdio_i;
      if (k >= 3) data = {data[14:0], mdio_i};
      #80 mdc = 1'b0;
    end
    #160;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    oe_hi    = 0;
    sr_hi    = 0;
    reset    = 1'b1;
    mdc      = 1'b0;
    st_en    = 1'b0;
    st_drv   = 1'b1;
    link_up  = 1'b0;

    #22;
    check_val("rst_oe", {31'h0, mdio_oe}, 32'h0);
    check_val("rst_o", {31'h0, mdio_o}, 32'h1);
    check_val("rst_ctrl", {16'h0, ctrl_reg}, 32'h1140);
    check_val("rst_sr", {31'h0, soft_reset}, 32'h0);
    #11 reset = 1'b0;
    #40;

    // Basic write then read back.
    write_frame(32, 5'd1, 5'd4, 16'hABCD);
    read_frame(5'd1, 5'd4, rd, ta2);
    check_val("rd4", {16'h0, rd}, 32'hABCD);
    check_val("rd4_ta2", {31'h0, ta2}, 32'h0);
    check_val("rd4_release", {31'h0, mdio_oe}, 32'h0);

    // Foreign PHY address: never drive, next frame still decoded.
    oe_snap = oe_hi;
    read_frame(5'd2, 5'd4, rd, ta2);
    check_val("phy2_oe", oe_hi - oe_snap, 0);
    check_val("phy2_bus", {16'h0, rd}, 32'hFFFF);
    read_frame(5'd1, 5'd4, rd, ta2);
    check_val("after_phy2", {16'h0, rd}, 32'hABCD);

    // Short preamble: write ignored.
    write_frame(31, 5'd1, 5'd5, 16'h1234);
    read_frame(5'd1, 5'd5, rd, ta2);
    check_val("short_pre", {16'h0, rd}, 32'h0);
    check_val("short_pre_ctrl", {16'h0, ctrl_reg}, 32'h1140);

    // Plain control write, no reset pulse.
    sr_snap = sr_hi;
    write_frame(32, 5'd1, 5'd0, 16'h1200);
    check_val("ctrl_1200", {16'h0, ctrl_reg}, 32'h1200);
    check_val("ctrl_1200_sr", sr_hi - sr_snap, 0);

    // Soft reset: single one-clock pulse, bit 15 not stored.
    sr_snap = sr_hi;
    write_frame(32, 5'd1, 5'd0, 16'h8000);
    check_val("sr_pulse", sr_hi - sr_snap, 1);
    check_val("sr_ctrl", {16'h0, ctrl_reg}, 32'h0);
    read_frame(5'd1, 5'd0, rd, ta2);
    check_val("sr_rd0", {16'h0, rd}, 32'h0);

    // Read-only registers.
    link_up = 1'b1;
    read_frame(5'd1, 5'd1, rd, ta2);
    check_val("rd1_up", {16'h0, rd}, 32'h0004);
    link_up = 1'b0;
    read_frame(5'd1, 5'd1, rd, ta2);
    check_val("rd1_down", {16'h0, rd}, 32'h0000);
    read_frame(5'd1, 5'd2, rd, ta2);
    check_val("rd2", {16'h0, rd}, 32'h0141);
    write_frame(32, 5'd1, 5'd3, 16'hFFFF);
    read_frame(5'd1, 5'd3, rd, ta2);
    check_val("rd3_ro", {16'h0, rd}, 32'h0CC0);

    // Reset while D8 is on the bus.
    send_header(32, 2'b10, 5'd1, 5'd4);
    st_en = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      #80 mdc = 1'b1;
      #80 mdc = 1'b0;
    end
    check_val("mid_oe_on", {31'h0, mdio_oe}, 32'h1);
    #7 reset = 1'b1;
    #1;
    check_val("mid_oe_off", {31'h0, mdio_oe}, 32'h0);
    check_val("mid_o", {31'h0, mdio_o}, 32'h1);
    #23 reset = 1'b0;
    #40;
    check_val("mid_ctrl", {16'h0, ctrl_reg}, 32'h1140);
    read_frame(5'd1, 5'd2, rd, ta2);
    check_val("post_rst_rd2", {16'h0, rd}, 32'h0141);
    check_val("post_rst_ta2", {31'h0, ta2}, 32'h0);
    read_frame(5'd1, 5'd4, rd, ta2);
    check_val("post_rst_rd4", {16'h0, rd}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1, the responder's Clause-22 PHY address.
REQ-002 SHALL have parameter PHY_ID, default 32'h0141_0CC0, read-only value of regs 2 (bits 31:16) and 3 (bits 15:0).
REQ-003 SHALL have port clock, input, 1, the single system clock; it must run at least 8x MDC.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port mdc, input, 1, asynchronous management clock from the station.
REQ-006 SHALL have port mdio_i, input, 1, MDIO pad input.
REQ-007 SHALL have port mdio_o, output, 1, MDIO drive value.
REQ-008 SHALL have port mdio_oe, output, 1, MDIO drive enable (1 = drive).
REQ-009 SHALL have port link_up, input, 1, reflected live in reg 1 bit 2.
REQ-010 SHALL have port ctrl_reg, output, 16, current reg 0 contents.
REQ-011 SHALL have port soft_reset, output, 1, one-clock pulse on a write of reg 0 with bit 15 set.

Function
REQ-012 SHALL pass mdc and mdio_i through 2-flop synchronizers; an MDC rising edge is detected from the synced value; all protocol actions occur on detected edges.
REQ-013 SHALL run states IDLE, START, OP, PHYAD, REGAD, TA, RD_DATA, WR_DATA.
REQ-014 IDLE: counts consecutive sampled 1s (saturating at 32); a 0 with count < 32 clears the count; a 0 with count = 32 -> START.
REQ-015 START: sampled 1 -> OP; sampled 0 -> IDLE with count cleared.
REQ-016 OP: 2 bits MSB first; 10 = read, 01 = write, 00/11 -> IDLE.
REQ-017 PHYAD: 5 bits MSB first; after the 5th bit, mismatch with PHY_ADDR -> IDLE, no drive.
REQ-018 REGAD: 5 bits MSB first, latched into a 5-bit address.
REQ-019 TA (read): on the 1st TA edge drive mdio_oe=1, mdio_o=0; drive D15..D0 on the next 16 edges; release mdio_oe=0 on the following edge -> IDLE.
REQ-020 TA (write): 2 TA bits sampled and ignored; WR_DATA shifts in 16 bits MSB first; the register updates in the clock after the 16th edge -> IDLE.
REQ-021 mdio_o/mdio_oe SHALL change only on detected edges, i.e. 3 clocks after the pad MDC rise.
REQ-022 Register file: 32 x 16. Reg 1 reads {13'h0, link_up, 2'b0} and is read-only; regs 2/3 are read-only per PHY_ID; writes to read-only regs are silently dropped.
REQ-023 Write of reg 0 with bit 15 = 1: soft_reset pulses 1 clock and stored bit 15 remains 0.
REQ-024 Read data SHALL be captured at the 1st TA edge; a write completing later does not alter a read in progress.
REQ-025 mdio_oe SHALL never be 1 outside TA2/RD_DATA of an address-matched read.

Reset
REQ-026 On reset: state IDLE, preamble count 0, mdio_oe=0, mdio_o=1, soft_reset=0, reg 0 = 16'h1140, other writable regs 0, synchronizers 0.
REQ-027 Reset mid-frame SHALL release MDIO immediately (asynchronously) and discard any partial write.

Structure
REQ-028 State enum, opcode constants and register-index constants SHALL live in shared package mdio_pkg.
REQ-029 The synchronizer plus edge detector SHALL be sub-module mdio_sync_edge; the FSM and register file stay in mdio_responder.

Verification
REQ-030 32 ones, then write PHYAD=1, REGAD=4, data 16'hABCD; then read reg 4 -> read returns 16'hABCD with TA2 = 0.
REQ-031 Read with PHYAD=2 -> mdio_oe stays 0 for the whole frame; the next valid frame is still decoded.
REQ-032 Only 31 preamble ones before ST -> frame ignored, no register changes.
REQ-033 Write reg 0 = 16'h8000 -> exactly one soft_reset pulse; reg 0 then reads 16'h0000.
REQ-034 Read reg 1 with link_up=1 -> 16'h0004; read reg 2 -> 16'h0141; write reg 3 -> reg 3 is unchanged.
REQ-035 Assert reset during RD_DATA bit 8 -> mdio_oe=0 within the same clock; a following full read frame succeeds.
